// File: rtl/regfile_multiport.sv
// Multi-read-port register file with sequential clear engine and optional hardwired-zero entry 0.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_multiport #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         write_enable,
  input  logic [ADDR_WIDTH-1:0]        write_reg,
  input  logic [DATA_WIDTH-1:0]        write_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] read_reg,
  output logic [NUM_RD*DATA_WIDTH-1:0] read_data,
  input  logic                         clear_req,
  output logic                         busy,
  output logic                         write_ready,
  output logic                         clear_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // One extra counter bit so DEPTH-1 is reached without wrapping for any ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  clear_done_q, clear_done_d;
  logic                  wr_hit_zero;
  logic                  wr_fire;

  assign busy        = (state_q == ST_CLEAR);
  assign write_ready = ~busy;
  assign clear_done  = clear_done_q;

  assign wr_hit_zero = (ZERO_REG != 0) && (write_reg == '0);
  assign wr_fire     = write_enable && write_ready && !wr_hit_zero;

  always_comb begin
    regs_d       = regs_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A clear request wins over a write presented in the same cycle.
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end else if (wr_fire) begin
          regs_d[write_reg] = write_data;
        end
      end
      ST_CLEAR: begin
        regs_d[cnt_q[ADDR_WIDTH-1:0]] = '0;
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d      = ST_IDLE;
          clear_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      regs_q       <= '{default: '0};
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      regs_q       <= regs_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_val;

    always_comb begin
      rd_addr = read_reg[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd_val  = regs_q[rd_addr];
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_val = '0;
      end
`ifdef REGFILE_BYPASS_EN
      if (wr_fire && (rd_addr == write_reg)) begin
        rd_val = write_data;
      end
`endif
    end

    assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = rd_val;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport (4 read ports, 32 entries, ZERO_REG=1).
module tb_regfile_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              write_enable;
  logic [AW-1:0]     write_reg;
  logic [DW-1:0]     write_data;
  logic [NR*AW-1:0]  read_reg;
  logic [NR*DW-1:0]  read_data;
  logic              clear_req;
  logic              busy;
  logic              write_ready;
  logic              clear_done;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_multiport #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .NUM_RD    (NR),
    .ZERO_REG  (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .write_enable(write_enable),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .read_reg    (read_reg),
    .read_data   (read_data),
    .clear_req   (clear_req),
    .busy        (busy),
    .write_ready (write_ready),
    .clear_done  (clear_done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    read_reg[k*AW +: AW] = a;
  endtask

  function automatic logic [DW-1:0] rd(input int k);
    return read_data[k*DW +: DW];
  endfunction

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_enable = 1'b1;
    write_reg    = a;
    write_data   = d;
    tick();
    write_enable = 1'b0;
  endtask

  initial begin : stim
    int busy_cnt;
    int done_cnt;
    int done_at;
    int guard;
    logic [DW-1:0] fwd_exp;

    reset = 1'b1; write_enable = 1'b0; write_reg = '0; write_data = '0;
    read_reg = '0; clear_req = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    for (int k = 0; k < NR; k++) set_rd(k, AW'(k + 1));
    #1;
    check("rst_busy", DW'(busy), 32'd0);
    check("rst_wready", DW'(write_ready), 32'd1);
    check("rst_done", DW'(clear_done), 32'd0);
    for (int k = 0; k < NR; k++) check($sformatf("rst_rd%0d", k), rd(k), 32'd0);

    // Same-cycle write/read of reg 1
    set_rd(0, 5'd1);
    write_enable = 1'b1; write_reg = 5'd1; write_data = 32'hFACEBEEF;
    #1;
`ifdef REGFILE_BYPASS_EN
    fwd_exp = 32'hFACEBEEF;
`else
    fwd_exp = 32'h00000000;
`endif
    check("same_cycle_rd", rd(0), fwd_exp);
    tick();
    write_enable = 1'b0;
    #1;
    check("after_wr_rd", rd(0), 32'hFACEBEEF);

    // Basic write/read on two ports
    do_write(5'd1, 32'hAABBCCDD);
    do_write(5'd2, 32'h12345678);
    set_rd(0, 5'd1); set_rd(1, 5'd2);
    #1;
    check("rd_p0_r1", rd(0), 32'hAABBCCDD);
    check("rd_p1_r2", rd(1), 32'h12345678);

    // Zero register: write discarded, reads 0, no forwarding
    for (int k = 0; k < NR; k++) set_rd(k, 5'd0);
    write_enable = 1'b1; write_reg = 5'd0; write_data = 32'hDEADBEEF;
    #1;
    check("zero_during_wr", rd(2), 32'd0);
    tick();
    write_enable = 1'b0;
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("zero_rd%0d", k), rd(k), 32'd0);

    // All four ports on reg 3 while writing reg 4
    do_write(5'd3, 32'h00000003);
    for (int k = 0; k < NR; k++) set_rd(k, 5'd3);
    write_enable = 1'b1; write_reg = 5'd4; write_data = 32'h44444444;
    #1;
    for (int k = 0; k < NR; k++) check($sformatf("same_addr_rd%0d", k), rd(k), 32'h00000003);
    tick();
    write_enable = 1'b0;
    set_rd(0, 5'd4);
    #1;
    check("rd_r4", rd(0), 32'h44444444);

    // Fill regs 1..31, then sequential clear
    for (int i = 1; i < 32; i++) do_write(AW'(i), 32'h10000000 | i);
    set_rd(0, 5'd31);
    #1;
    check("fill_r31", rd(0), 32'h1000001F);

    // Clear request together with a write to reg 31: write must be dropped
    clear_req = 1'b1;
    write_enable = 1'b1; write_reg = 5'd31; write_data = 32'h0BADF00D;
    tick();
    clear_req = 1'b0;
    write_enable = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; guard = 0;
    while (busy && guard < 100) begin
      busy_cnt++;
      if (clear_done) done_cnt++;
      if (busy_cnt == 6) begin
        write_enable = 1'b1; write_reg = 5'd5; write_data = 32'hFACEBEEF;
      end else begin
        write_enable = 1'b0;
      end
      if (busy_cnt == 11) begin
        set_rd(0, 5'd9); set_rd(1, 5'd10); set_rd(2, 5'd31); set_rd(3, 5'd5);
        #1;
        check("mid_cleared_r9", rd(0), 32'd0);
        check("mid_old_r10", rd(1), 32'h1000000A);
        check("mid_old_r31", rd(2), 32'h1000001F);
        check("mid_r5_cleared", rd(3), 32'd0);
        check("mid_wready", DW'(write_ready), 32'd0);
      end
      clear_req = (busy_cnt == 15);
      tick();
      guard++;
    end
    clear_req = 1'b0;
    write_enable = 1'b0;
    check("clear_busy_cycles", DW'(busy_cnt), 32'd32);
    if (clear_done) begin
      done_cnt++;
      done_at = busy_cnt;
    end
    check("clear_done_at_end", DW'(done_at), 32'd32);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (clear_done) done_cnt++;
    end
    check("clear_done_count", DW'(done_cnt), 32'd1);
    check("post_clear_busy", DW'(busy), 32'd0);
    for (int a = 0; a < 32; a += NR) begin
      for (int k = 0; k < NR; k++) set_rd(k, AW'(a + k));
      #1;
      for (int k = 0; k < NR; k++) check($sformatf("cleared_r%0d", a + k), rd(k), 32'd0);
    end

    // Reset aborts a clear at counter 10
    do_write(5'd7, 32'h77777777);
    do_write(5'd31, 32'h31313131);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_busy_before", DW'(busy), 32'd1);
    reset = 1'b1;
    write_enable = 1'b1; write_reg = 5'd20; write_data = 32'h20202020;
    tick();
    reset = 1'b0;
    write_enable = 1'b0;
    check("abort_busy", DW'(busy), 32'd0);
    check("abort_done", DW'(clear_done), 32'd0);
    check("abort_wready", DW'(write_ready), 32'd1);
    set_rd(0, 5'd7); set_rd(1, 5'd31); set_rd(2, 5'd20); set_rd(3, 5'd15);
    #1;
    check("abort_r7", rd(0), 32'd0);
    check("abort_r31", rd(1), 32'd0);
    check("abort_r20", rd(2), 32'd0);
    check("abort_r15", rd(3), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (clear_done || busy) done_cnt++;
    end
    check("abort_no_done", DW'(done_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 Parameter DATA_WIDTH, default 32: bit width of each register.
REQ-002 Parameter ADDR_WIDTH, default 5: register address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter NUM_RD, default 2: number of independent read ports, minimum 1.
REQ-004 Parameter ZERO_REG, default 1: when 1, entry 0 is hardwired to zero; when 0, entry 0 is an ordinary register.
REQ-005 clock  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 write_enable  input  1  write request for the current cycle.
REQ-008 write_reg  input  ADDR_WIDTH  write address.
REQ-009 write_data  input  DATA_WIDTH  write data.
REQ-010 read_reg  input  NUM_RD*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
REQ-011 read_data  output  NUM_RD*DATA_WIDTH  packed read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-012 clear_req  input  1  one-cycle request to start a sequential clear of all entries.
REQ-013 busy  output  1  high while a sequential clear is in progress.
REQ-014 write_ready  output  1  equals !busy; a write is accepted only when it is high.
REQ-015 clear_done  output  1  one-cycle pulse when a sequential clear completes.

Function
REQ-016 Reads SHALL be combinational: read_data port k returns the entry at read_reg port k in the same cycle, with zero added latency.
REQ-017 With ZERO_REG=1, reads of address 0 SHALL return 0, and writes to address 0 SHALL be discarded.
REQ-018 A write SHALL update the entry on the rising edge when write_enable=1 and write_ready=1; a read of that entry from the next cycle onward returns the new data.
REQ-019 The FSM SHALL have two states: IDLE and CLEAR.
REQ-020 The FSM SHALL go from IDLE to CLEAR on the rising edge where clear_req=1, load clear counter = 0, and set busy=1 from the next cycle.
REQ-021 In CLEAR, the FSM SHALL zero the entry at the clear counter on each rising edge, then increment the counter.
REQ-022 The FSM SHALL return from CLEAR to IDLE on the edge that clears entry DEPTH-1, which makes the clear take exactly DEPTH cycles.
REQ-023 clear_done SHALL be high for exactly the one cycle after the edge that clears entry DEPTH-1; busy is 0 in that same cycle.
REQ-024 The clear counter SHALL be ADDR_WIDTH+1 bits wide, with no wrap before completion; DEPTH=2 and DEPTH=256 SHALL both be supported.
REQ-025 clear_req while busy=1 SHALL be ignored and SHALL NOT restart the counter.
REQ-026 clear_req and write_enable in the same IDLE cycle: the clear SHALL start and the write SHALL be dropped.
REQ-027 Writes while busy=1 SHALL be dropped with no side effect.
REQ-028 Reads while busy=1 SHALL return current contents: already-cleared entries read 0, and not-yet-cleared entries keep their old values.
REQ-029 All read ports SHALL be independent; any number of ports may address the same entry in the same cycle.

Reset
REQ-030 On a rising edge with reset=1, all entries SHALL be set to 0, FSM to IDLE, and the clear counter to 0.
REQ-031 After reset, busy=0, write_ready=1, clear_done=0, and all read_data ports read 0.
REQ-032 reset SHALL take priority over clear_req and write_enable, and SHALL abort a clear in progress with no clear_done pulse.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN, when defined, SHALL compile in write-to-read forwarding.
  - Forwarding applies when write_enable=1, write_ready=1, and read_reg port k equals write_reg; the address must also be non-zero when ZERO_REG=1.
  - Under those conditions, read_data port k returns write_data in the same cycle.
REQ-034 Without REGFILE_BYPASS_EN, read_data port k SHALL return the stored (old) value until the write edge.

Verification
REQ-035 Reset, then write 32'hAABBCCDD to reg 1 and 32'h12345678 to reg 2, then read port0=1, port1=2 -> AABBCCDD and 12345678.
REQ-036 With ZERO_REG=1, write 32'hDEADBEEF to reg 0, then read reg 0 on all ports -> 00000000.
REQ-037 Fill regs 1..31, pulse clear_req -> busy=1 for exactly 32 cycles, then clear_done pulses once, then every entry reads 0; a write of 32'hFACEBEEF to reg 5 mid-clear is dropped.
REQ-038 Assert reset at clear counter 10 -> busy=0 next cycle, no clear_done, all entries read 0.
REQ-039 Write 32'hFACEBEEF to reg 1 while reading reg 1 in the same cycle -> reads FACEBEEF with REGFILE_BYPASS_EN, and the old value (00000000 after reset) without it.
REQ-040 With NUM_RD=4, all four ports read reg 3 = 32'h0000_0003 during a write to reg 4 -> all four ports return 00000003.
